perceptron_layer_scheduler: RTL and testbench

- Time-multiplexes one Perceptron instance across the M neurons of a dense layer.
- Accepts one input vector through a valid/ready handshake and fetches each neuron's weights and bias from a weight memory.
- Drives the Perceptron's x/w/b ports, captures y per neuron, and presents the full M-wide result vector with valid/ready.
- Sits between the layer input FIFO and the next layer in the NPU datapath; the Perceptron is instantiated alongside it by the parent.

---
 rtl/perceptron_sched_pkg.sv | 26 ++
 rtl/perceptron_layer_scheduler_perf.sv | 22 ++
 rtl/perceptron_layer_scheduler.sv | 115 +++++++++++
 tb/tb_perceptron_layer_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_sched_pkg.sv
// Shared types and helpers for the perceptron layer scheduler.
// Element width comes from the DATA_WIDTH macro (normally set by width.svh); 8 when not defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package perceptron_sched_pkg;

  localparam int unsigned DATA_WIDTH = `DATA_WIDTH;

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Address width for M neurons, never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned m);
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/perceptron_layer_scheduler_perf.sv
// Saturating activity counters for the layer scheduler (used when PERCEPTRON_SCHED_PERF_EN is defined).
module perceptron_sched_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        busy,
  input  logic        layer_done,
  output logic [31:0] busy_cycles,
  output logic [15:0] layers_done
);

  // Count busy cycles and completed layers, both sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cycles <= '0;
      layers_done <= '0;
    end else begin
      if (busy && (busy_cycles != '1)) busy_cycles <= busy_cycles + 32'(1);
      if (layer_done && (layers_done != '1)) layers_done <= layers_done + 16'(1);
    end
  end

endmodule

// File: rtl/perceptron_layer_scheduler.sv
// Time-multiplexes one Perceptron across the M neurons of a dense layer.
// Optional PERCEPTRON_SCHED_PERF_EN adds busy_cycles / layers_done counter ports.
module perceptron_layer_scheduler
  import perceptron_sched_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned M          = 8,
  parameter int unsigned PE_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  data_t [N-1:0]                  in_x,
  output logic                           out_valid,
  input  logic                           out_ready,
  output data_t [M-1:0]                  out_y,
  output logic                           mem_rd_en,
  output logic [addr_width(M)-1:0]       mem_addr,
  input  data_t [N-1:0]                  mem_w,
  input  data_t                          mem_b,
  output data_t [N-1:0]                  pe_x,
  output data_t [N-1:0]                  pe_w,
  output data_t                          pe_b,
  input  data_t                          pe_y
`ifdef PERCEPTRON_SCHED_PERF_EN
  ,
  output logic [31:0]                    busy_cycles,
  output logic [15:0]                    layers_done
`endif
);

  localparam int unsigned AW = addr_width(M);
  localparam int unsigned CW = (PE_LATENCY >= 1) ? $clog2(PE_LATENCY + 1) : 1;

  state_t          state, state_next;
  logic [AW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic            cnt_last;
  logic            idx_last;
  logic            accept;

  assign cnt_last = (cnt == CW'(PE_LATENCY));
  assign idx_last = (idx == AW'(M - 1));

  // Handshake and memory strobes decode directly from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign mem_rd_en = (state == FETCH);
  assign mem_addr  = idx;
  assign accept    = in_valid && (state == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: one FETCH/ISSUE/WAIT pass per neuron, then hold results in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = FETCH;
      FETCH:   state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt_last) state_next = idx_last ? DONE : FETCH;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch activations, stage weights, pace the PE and capture its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      cnt   <= '0;
      pe_x  <= '0;
      pe_w  <= '0;
      pe_b  <= '0;
      out_y <= '0;
    end else begin
      if (accept) begin
        pe_x <= in_x;
        idx  <= '0;
      end
      if (state == ISSUE) begin
        pe_w <= mem_w;
        pe_b <= mem_b;
        cnt  <= '0;
      end
      if (state == WAIT) begin
        cnt <= cnt + CW'(1);
        if (cnt_last) begin
          out_y[idx] <= pe_y;
          if (!idx_last) idx <= idx + AW'(1);
        end
      end
    end
  end

`ifdef PERCEPTRON_SCHED_PERF_EN
  logic busy;
  assign busy = (state == FETCH) || (state == ISSUE) || (state == WAIT);

  perceptron_sched_perf u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .busy        (busy),
    .layer_done  (out_valid && out_ready),
    .busy_cycles (busy_cycles),
    .layers_done (layers_done)
  );
`endif

endmodule

// File: tb/tb_perceptron_layer_scheduler.sv
// Self-checking bench for perceptron_layer_scheduler with a weight memory and Perceptron model.
module tb_perceptron_layer_scheduler;
  import perceptron_sched_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned M = 8;
  localparam int unsigned L = 1;
  localparam int LAYER_CYC = M * (L + 3);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  data_t [N-1:0]  in_x = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  data_t [M-1:0]  out_y;
  logic           mem_rd_en;
  logic [2:0]     mem_addr;
  data_t [N-1:0]  mem_w = '0;
  data_t          mem_b = '0;
  data_t [N-1:0]  pe_x;
  data_t [N-1:0]  pe_w;
  data_t          pe_b;
  data_t          pe_y = '0;
`ifdef PERCEPTRON_SCHED_PERF_EN
  logic [31:0]    busy_cycles;
  logic [15:0]    layers_done;
`endif

  int vectors = 0;
  int miscompares = 0;

  data_t tab_w [M][N];
  data_t tab_b [M];

  bit  mon_en = 1'b0;
  int  addr_q[$];
  int  rd_double = 0;
  bit  rd_prev = 1'b0;

  perceptron_layer_scheduler #(.N(N), .M(M), .PE_LATENCY(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_w     (mem_w),
    .mem_b     (mem_b),
    .pe_x      (pe_x),
    .pe_w      (pe_w),
    .pe_b      (pe_b),
    .pe_y      (pe_y)
`ifdef PERCEPTRON_SCHED_PERF_EN
    ,
    .busy_cycles (busy_cycles),
    .layers_done (layers_done)
`endif
  );

  always #5 clk = ~clk;

  // Weight memory: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      for (int i = 0; i < N; i++) mem_w[i] <= tab_w[mem_addr][i];
      mem_b <= tab_b[mem_addr];
    end else begin
      for (int i = 0; i < N; i++) mem_w[i] <= data_t'($urandom);
      mem_b <= data_t'($urandom);
    end
  end

  // Perceptron model with one register stage (no activation).
  always @(posedge clk) begin
    int acc;
    acc = int'($signed(pe_b));
    for (int i = 0; i < N; i++) acc += int'($signed(pe_x[i])) * int'($signed(pe_w[i]));
    pe_y <= data_t'(acc);
  end

  // Memory-port observer.
  always @(negedge clk) begin
    if (mon_en && mem_rd_en) begin
      addr_q.push_back(int'(mem_addr));
      if (rd_prev) rd_double++;
    end
    rd_prev = mem_rd_en;
  end

  // Layer reference: dense dot product plus bias, wrapped to the element width.
  function automatic data_t ref_y(input int k, input data_t x [N]);
    int acc;
    acc = int'(tab_b[k]);
    for (int i = 0; i < N; i++) acc += int'(x[i]) * int'(tab_w[k][i]);
    return data_t'(acc);
  endfunction

  task automatic randomize_tables();
    for (int k = 0; k < M; k++) begin
      for (int i = 0; i < N; i++) tab_w[k][i] = data_t'($urandom_range(0, 255));
      tab_b[k] = data_t'($urandom_range(0, 255));
    end
  endtask

  // Offer x, wait for acceptance, then count cycles to out_valid while watching pe_x.
  task automatic run_layer(input data_t x [N], input bit scramble, output int cycles, output int px_bad);
    int t;
    cycles = -1;
    px_bad = 0;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) return;
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) in_x[i] = x[i];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) in_x[i] = scramble ? data_t'(-1) : data_t'($urandom);
    for (int i = 0; i < N; i++) if (pe_x[i] !== x[i]) px_bad++;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (pe_x[i] !== x[i]) px_bad++;
      if (out_valid === 1'b1) begin
        cycles = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (mem_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_rd_en got %b want 0", mem_rd_en); end
    vectors++; if (mem_addr !== 3'd0) begin miscompares++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
    vectors++; if (pe_x !== '0) begin miscompares++; $display("FAIL reset_pe_x got %h want 0", pe_x); end
    vectors++; if (pe_w !== '0) begin miscompares++; $display("FAIL reset_pe_w got %h want 0", pe_w); end
    vectors++; if (pe_b !== '0) begin miscompares++; $display("FAIL reset_pe_b got %h want 0", pe_b); end
    vectors++; if (out_y !== '0) begin miscompares++; $display("FAIL reset_out_y got %h want 0", out_y); end
  endtask

  task automatic test_identity();
    data_t x [N];
    int cyc, pxb;
    for (int k = 0; k < M; k++) begin
      for (int i = 0; i < N; i++) tab_w[k][i] = (i == 0) ? data_t'(1) : data_t'(0);
      tab_b[k] = data_t'(k);
    end
    x[0] = 8'sd5; x[1] = 8'sd9; x[2] = 8'sd9; x[3] = 8'sd9;
    addr_q.delete();
    rd_double = 0;
    mon_en = 1'b1;
    run_layer(x, 1'b1, cyc, pxb);
    mon_en = 1'b0;
    vectors++; if (cyc != LAYER_CYC) begin miscompares++; $display("FAIL ident_latency got %0d want %0d", cyc, LAYER_CYC); end
    vectors++; if (pxb != 0) begin miscompares++; $display("FAIL ident_pe_x_stable got %0d bad samples want 0", pxb); end
    for (int k = 0; k < M; k++) begin
      vectors++;
      if (out_y[k] !== data_t'(5 + k)) begin
        miscompares++; $display("FAIL ident_out_y[%0d] got %0d want %0d", k, out_y[k], 5 + k);
      end
    end
    vectors++; if (addr_q.size() != M) begin miscompares++; $display("FAIL mem_rd_count got %0d want %0d", addr_q.size(), M); end
    for (int k = 0; k < M && k < addr_q.size(); k++) begin
      vectors++;
      if (addr_q[k] != k) begin miscompares++; $display("FAIL mem_addr_seq[%0d] got %0d want %0d", k, addr_q[k], k); end
    end
    vectors++; if (rd_double != 0) begin miscompares++; $display("FAIL mem_rd_back_to_back got %0d want 0", rd_double); end
  endtask

  // Entered with the identity layer sitting in DONE and out_ready low.
  task automatic test_backpressure();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = c[0];
      for (int i = 0; i < N; i++) in_x[i] = data_t'($urandom);
      @(posedge clk);
      #1;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid cyc %0d got %b want 1", c, out_valid); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cyc %0d got %b want 0", c, in_ready); end
      for (int k = 0; k < M; k++) begin
        vectors++;
        if (out_y[k] !== data_t'(5 + k)) begin
          miscompares++; $display("FAIL bp_out_y[%0d] cyc %0d got %0d want %0d", k, c, out_y[k], 5 + k);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      vectors++; if (mem_rd_en !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++; $display("FAIL idle_quiet got rd_en=%b in_ready=%b want 0/1", mem_rd_en, in_ready);
      end
    end
    for (int k = 0; k < M; k++) begin
      vectors++;
      if (out_y[k] !== data_t'(5 + k)) begin miscompares++; $display("FAIL idle_keep_out_y[%0d] got %0d want %0d", k, out_y[k], 5 + k); end
    end
  endtask

  task automatic test_random_layers();
    data_t x [N];
    int cyc, pxb, d;
    for (int n = 0; n < 4; n++) begin
      randomize_tables();
      for (int i = 0; i < N; i++) x[i] = data_t'($urandom_range(0, 255));
      run_layer(x, 1'b0, cyc, pxb);
      vectors++; if (cyc != LAYER_CYC) begin miscompares++; $display("FAIL rand%0d_latency got %0d want %0d", n, cyc, LAYER_CYC); end
      vectors++; if (pxb != 0) begin miscompares++; $display("FAIL rand%0d_pe_x_stable got %0d want 0", n, pxb); end
      for (int k = 0; k < M; k++) begin
        vectors++;
        if (out_y[k] !== ref_y(k, x)) begin
          miscompares++; $display("FAIL rand%0d_out_y[%0d] got %0d want %0d", n, k, out_y[k], ref_y(k, x));
        end
      end
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rand%0d_handshake got out_valid=%b want 0", n, out_valid); end
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_layer();
    data_t x [N];
    int t, cyc, pxb;
    randomize_tables();
    for (int i = 0; i < N; i++) x[i] = data_t'($urandom_range(1, 255));
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) in_x[i] = x[i];
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!(mem_rd_en === 1'b1 && mem_addr === 3'd3) && t < 100) begin
      @(negedge clk);
      t++;
    end
    vectors++; if (t >= 100) begin miscompares++; $display("FAIL mid_reach_neuron3 got timeout want fetch of 3"); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_strobes got out_valid=%b rd_en=%b want 0/0", out_valid, mem_rd_en);
    end
    vectors++; if (pe_x !== '0 || pe_w !== '0 || pe_b !== '0) begin
      miscompares++; $display("FAIL mid_rst_pe got x=%h w=%h b=%h want 0", pe_x, pe_w, pe_b);
    end
    vectors++; if (out_y !== '0) begin miscompares++; $display("FAIL mid_rst_out_y got %h want 0", out_y); end
    vectors++; if (mem_addr !== 3'd0) begin miscompares++; $display("FAIL mid_rst_mem_addr got %0d want 0", mem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_release_in_ready got %b want 1", in_ready); end
    randomize_tables();
    for (int i = 0; i < N; i++) x[i] = data_t'($urandom_range(0, 255));
    run_layer(x, 1'b0, cyc, pxb);
    vectors++; if (cyc != LAYER_CYC) begin miscompares++; $display("FAIL mid_after_latency got %0d want %0d", cyc, LAYER_CYC); end
    for (int k = 0; k < M; k++) begin
      vectors++;
      if (out_y[k] !== ref_y(k, x)) begin
        miscompares++; $display("FAIL mid_after_out_y[%0d] got %0d want %0d", k, out_y[k], ref_y(k, x));
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    data_t x [N];
    int cyc, pxb;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    randomize_tables();
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < N; i++) x[i] = data_t'($urandom_range(0, 255));
      run_layer(x, 1'b0, cyc, pxb);
      vectors++; if (cyc != LAYER_CYC) begin miscompares++; $display("FAIL b2b%0d_latency got %0d want %0d", n, cyc, LAYER_CYC); end
      for (int k = 0; k < M; k++) begin
        vectors++;
        if (out_y[k] !== ref_y(k, x)) begin
          miscompares++; $display("FAIL b2b%0d_out_y[%0d] got %0d want %0d", n, k, out_y[k], ref_y(k, x));
        end
      end
    end
    @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_final got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
`ifdef PERCEPTRON_SCHED_PERF_EN
    vectors++; if (layers_done !== 16'd2) begin miscompares++; $display("FAIL perf_layers_done got %0d want 2", layers_done); end
    vectors++; if (busy_cycles !== 32'(2 * LAYER_CYC)) begin
      miscompares++; $display("FAIL perf_busy_cycles got %0d want %0d", busy_cycles, 2 * LAYER_CYC);
    end
`endif
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < M; k++) begin
      for (int i = 0; i < N; i++) tab_w[k][i] = '0;
      tab_b[k] = '0;
    end
    test_reset();
    test_identity();
    test_backpressure();
    test_random_layers();
    test_reset_mid_layer();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
